// File: rtl/seq_det_scheduler.sv
// Four serial requester channels share one pattern comparator through a round-robin grant.
// Each channel keeps its own shift history, fill count and saturating match counter.
module seq_det_scheduler #(
    parameter int N_CH  = 4,
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  bit_in,
    output logic [N_CH-1:0]  gnt,
    output logic             match_valid,
    output logic [1:0]       match_ch,
    input  logic [1:0]       cnt_rd_ch,
    output logic [7:0]       cnt_rd_data
);

    logic [1:0]       ptr;
    logic [PAT_W-1:0] pat_q;
    logic [2:0]       len_q;
    logic             ovl_q;

    logic [PAT_W-1:0] hist [N_CH];
    logic [3:0]       fill [N_CH];
    logic [7:0]       cnt  [N_CH];

    logic             gnt_any;
    logic [1:0]       gnt_ch;
    logic [1:0]       idx;
    logic [PAT_W-1:0] hist_sel;
    logic [3:0]       fill_sel;
    logic [PAT_W-1:0] h_next;
    logic [3:0]       f_next;
    logic [PAT_W-1:0] mask;
    logic             hit;

    // Search starts just above the last granted channel and wraps modulo four.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = 2'd0;
        idx     = 2'd0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = ptr + 2'(k);
            if (!cfg_we && !gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx;
            end
        end
        gnt = gnt_any ? (N_CH'(1) << gnt_ch) : '0;
    end

    always_comb begin
        hist_sel = hist[gnt_ch];
        fill_sel = fill[gnt_ch];
        h_next   = {hist_sel[PAT_W-2:0], bit_in[gnt_ch]};
        f_next   = (fill_sel >= 4'(PAT_W)) ? 4'(PAT_W) : fill_sel + 4'd1;
        mask     = {PAT_W{1'b1}} >> (3'd7 - len_q);
        hit      = gnt_any && (f_next >= ({1'b0, len_q} + 4'd1))
                   && (((h_next ^ pat_q) & mask) == '0);
    end

    assign cnt_rd_data = cnt[cnt_rd_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= 2'd3;
            match_valid <= 1'b0;
            match_ch    <= 2'd0;
            pat_q       <= '0;
            len_q       <= 3'd0;
            ovl_q       <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= 4'd0;
                cnt[i]  <= 8'd0;
            end
        end else if (cfg_we) begin
            // Reconfiguration wipes every context but keeps arbitration fairness intact.
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            ovl_q       <= cfg_overlap;
            match_valid <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                hist[i] <= '0;
                fill[i] <= 4'd0;
                cnt[i]  <= 8'd0;
            end
        end else begin
            match_valid <= hit;
            if (hit) begin
                match_ch <= gnt_ch;
            end
            if (gnt_any) begin
                ptr          <= gnt_ch;
                hist[gnt_ch] <= h_next;
                fill[gnt_ch] <= (hit && !ovl_q) ? 4'd0 : f_next;
                if (hit && cnt[gnt_ch] != 8'hFF) begin
                    cnt[gnt_ch] <= cnt[gnt_ch] + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/seq_det_scheduler.md
SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 Parameter: N_CH, 4, number of serial requester channels (fixed at 4 for this block).
REQ-002 Parameter: PAT_W, 8, maximum pattern length in bits.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_we  input  1  load configuration and clear all channel contexts and counters.
REQ-006 cfg_pattern  input  8  target pattern; bit [len-1] is the oldest bit and bit 0 the newest.
REQ-007 cfg_len  input  3  pattern length minus one (1..8 bits).
REQ-008 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 req  input  4  per-channel request; the channel has a bit to deliver.
REQ-010 bit_in  input  4  per-channel serial data bit, valid while req[i]=1.
REQ-011 gnt  output  4  one-hot combinational grant; the bit of that channel is consumed at this edge.
REQ-012 match_valid  output  1  registered one-cycle pulse: a pattern completed.
REQ-013 match_ch  output  2  channel index of the match, valid with match_valid.
REQ-014 cnt_rd_ch  input  2  match-counter read select.
REQ-015 cnt_rd_data  output  8  combinational match count of channel cnt_rd_ch.

Function
REQ-016 The block SHALL time-share one pattern comparator among 4 channels, holding a per-channel context of 8-bit history hist[i] and 4-bit fill count fill[i].
REQ-017 Arbitration SHALL be round-robin: the grant goes to the first channel with req=1 searching upward (mod 4) from ptr+1, where ptr is the last granted channel.
REQ-018 At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req=0 or cfg_we=1.
REQ-019 On a grant to channel g, ptr SHALL update to g at that edge; with no grant, ptr SHALL hold.
REQ-020 Requesters hold req and bit_in until they see gnt; a request without a grant SHALL leave the context unchanged.
REQ-021 On a grant: h = {hist[g][6:0], bit_in[g]}; f = min(fill[g]+1, 8); match = (f >= len) and (h & mask) == (cfg_pattern & mask), where len = cfg_len+1 and mask holds the low len bits set.
REQ-022 The context update SHALL be hist[g] <= h; fill[g] <= f, except that on a match with cfg_overlap=0, fill[g] <= 0.
REQ-023 match_valid SHALL pulse for exactly one cycle, in the cycle after the completing grant edge (latency 1), with match_ch = g.
REQ-024 Match counter cnt[g] SHALL increment on each match and saturate at 255.
REQ-025 cfg_we=1 SHALL take priority over everything at its edge and SHALL:
  - latch cfg_pattern, cfg_len and cfg_overlap;
  - clear all hist, fill and cnt;
  - force match_valid to 0 in the next cycle;
  - leave ptr unchanged.
REQ-026 The configuration SHALL be stable between cfg_we pulses; the comparator SHALL use only latched configuration values.
REQ-027 A channel deasserting req mid-pattern SHALL keep its context; detection resumes on its next granted bit.

Reset
REQ-028 rst SHALL clear asynchronously:
  - gnt effect, match_valid=0, match_ch=0;
  - all hist=0, fill=0, cnt=0;
  - ptr=3, so channel 0 has first priority;
  - pattern=0, len field=0, overlap=0.
REQ-029 rst asserted mid-stream SHALL discard partial matches; the first post-reset grant SHALL go to the lowest requesting channel.

Verification
REQ-030 Setup: cfg pattern=0x09, cfg_len=3, overlap=1. Stimulus: ch0 only, bits 1,0,0,1,0,0,1 -> match_valid with match_ch=0 after bit 4 and bit 7; cnt[0]=2.
REQ-031 Same stimulus with overlap=0 -> single match after bit 4; cnt[0]=1.
REQ-032 req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001; then req=4'b0101 -> gnt alternates 0100 and 0001 according to ptr.
REQ-033 Setup: pattern=0x01, cfg_len=0. Stimulus: 300 granted ones on ch2 -> cnt[2] saturates at 255, and match_valid keeps pulsing every granted cycle.
REQ-034 cfg_we with req=4'b0010 -> gnt=0 that cycle; cnt and fill of all channels read 0 afterwards; ch1 is granted the following cycle.
REQ-035 rst mid-pattern (ch3 has fed 1,0,0) -> after release, feeding a single 1 on ch3 produces no match.
